dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the single-port word-addressed data memory. Port 0 serves the CPU load/store stage; port 1 serves the debug/DMA loader. The block accepts one request at a time, drives the memory's read/write strobes for exactly one cycle, and captures read data. It returns a one-cycle acknowledge with fixed latency. Illegal addresses are rejected with an error flag and no memory access.

---
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and one-shot access sequencer for the single-port data memory.
// Optional build macro DMEM_ARB_RR_EN: round-robin on ties; otherwise port 0 has fixed priority.
module dmem_arbiter #(
   parameter int DEPTH_WORDS = 64
) (
   input  logic        Clock,
   input  logic        ResetL,
   input  logic        Req0,
   input  logic        Req1,
   input  logic        We0,
   input  logic        We1,
   input  logic [31:0] Addr0,
   input  logic [31:0] Addr1,
   input  logic [31:0] WData0,
   input  logic [31:0] WData1,
   output logic [31:0] RData0,
   output logic [31:0] RData1,
   output logic        Ack0,
   output logic        Ack1,
   output logic        Err0,
   output logic        Err1,
   output logic [31:0] MemAddress,
   output logic [31:0] MemWriteData,
   output logic        MemoryRead,
   output logic        MemoryWrite,
   input  logic [31:0] MemReadData,
   output logic        Busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

   localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

   state_t      state, state_next;
   logic        accept;
   logic        winner;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_legal;
   logic        grant;
   logic        lat_we;
   logic        legal;

   assign accept = (state == IDLE) && (Req0 || Req1);

`ifdef DMEM_ARB_RR_EN
   // rr_ptr remembers the last granted port; a tie goes to the other one.
   logic rr_ptr;

   assign winner = (Req0 && Req1) ? ~rr_ptr : ~Req0;

   always_ff @(posedge Clock or negedge ResetL) begin
      if (!ResetL) begin
         rr_ptr <= 1'b1;
      end else if (accept) begin
         rr_ptr <= winner;
      end
   end
`else
   assign winner = ~Req0;
`endif

   assign sel_we    = winner ? We1    : We0;
   assign sel_addr  = winner ? Addr1  : Addr0;
   assign sel_wdata = winner ? WData1 : WData0;
   assign sel_legal = (sel_addr[1:0] == 2'b00) && ({2'b00, sel_addr[31:2]} < DEPTH_LIMIT);

   always_ff @(posedge Clock or negedge ResetL) begin
      if (!ResetL) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Strobes, Ack and Err decode straight from state, so an asynchronous
   // reset mid-ACCESS removes them at once and a pending write never lands.
   always_comb begin
      // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_next  = state;
      MemoryRead  = 1'b0;
      MemoryWrite = 1'b0;
      Ack0        = 1'b0;
      Ack1        = 1'b0;
      Err0        = 1'b0;
      Err1        = 1'b0;
      Busy        = 1'b1;
      case (state)
         IDLE: begin
            Busy = 1'b0;
            if (accept) state_next = ACCESS;
         end
         ACCESS: begin
            MemoryRead  = legal && !lat_we;
            MemoryWrite = legal &&  lat_we;
            state_next  = CAPTURE;
         end
         CAPTURE: begin
            state_next = DONE;
         end
         DONE: begin
            Ack0       = !grant;
            Ack1       =  grant;
            Err0       = !grant && !legal;
            Err1       =  grant && !legal;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge ResetL) begin
      if (!ResetL) begin
         grant        <= 1'b0;
         lat_we       <= 1'b0;
         legal        <= 1'b0;
         MemAddress   <= '0;
         MemWriteData <= '0;
         RData0       <= '0;
         RData1       <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
         if (accept) begin
            grant        <= winner;
            lat_we       <= sel_we;
            legal        <= sel_legal;
            MemAddress   <= sel_addr;
            MemWriteData <= sel_wdata;
         end
         if (state == CAPTURE) begin
            if (!legal) begin
               if (grant) RData1 <= '0;
               else       RData0 <= '0;
            end else if (!lat_we) begin
               if (grant) RData1 <= MemReadData;
               else       RData0 <= MemReadData;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 64-word memory.
// Expected tie order follows DMEM_ARB_RR_EN when the bench is built with it.
module tb_dmem_arbiter;

   logic        Clock;
   logic        ResetL;
   logic        Req0, Req1, We0, We1;
   logic [31:0] Addr0, Addr1, WData0, WData1;
   logic [31:0] RData0, RData1;
   logic        Ack0, Ack1, Err0, Err1;
   logic [31:0] MemAddress, MemWriteData;
   logic        MemoryRead, MemoryWrite;
   logic [31:0] MemReadData;
   logic        Busy;

   logic [31:0] mem [64];

   int n_tests = 0;
   int n_fail  = 0;

   dmem_arbiter #(.DEPTH_WORDS(64)) dut (
      .Clock(Clock), .ResetL(ResetL),
      .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
      .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
      .RData0(RData0), .RData1(RData1),
      .Ack0(Ack0), .Ack1(Ack1), .Err0(Err0), .Err1(Err1),
      .MemAddress(MemAddress), .MemWriteData(MemWriteData),
      .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
      .MemReadData(MemReadData), .Busy(Busy)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Memory: read sampled on the rising edge, write lands on the falling edge.
   always @(posedge Clock) if (MemoryRead) MemReadData <= mem[MemAddress[7:2]];
   always @(negedge Clock) if (MemoryWrite) mem[MemAddress[7:2]] <= MemWriteData;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic run_access(input bit port, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata,
                             output bit err, output int lat, output int nrd, output int nwr);
      bit got;
      got = 0; lat = 0; nrd = 0; nwr = 0; rdata = '0; err = 0;
      if (port) begin Req1 = 1; We1 = we; Addr1 = addr; WData1 = wdata; end
      else      begin Req0 = 1; We0 = we; Addr0 = addr; WData0 = wdata; end
      while (!got && lat < 20) begin
         tick();
         lat++;
         nrd += int'(MemoryRead);
         nwr += int'(MemoryWrite);
         if (port ? Ack1 : Ack0) begin
            got   = 1;
            rdata = port ? RData1 : RData0;
            err   = port ? Err1 : Err0;
         end
      end
      if (!got) lat = 99;
      Req0 = 0; Req1 = 0;
      tick();
      n_tests++;
      if ((Ack0 | Ack1) !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_width: ack still high one cycle later (got %b, want 0)", Ack0 | Ack1);
      end
   endtask

   task automatic test_reset();
      ResetL = 1; Req0 = 0; Req1 = 0; We0 = 0; We1 = 0;
      Addr0 = 0; Addr1 = 0; WData0 = 0; WData1 = 0;
      for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
      MemReadData = '0;
      #2 ResetL = 0;
      #1;
      n_tests++;
      if ({Ack0, Ack1, Err0, Err1, MemoryRead, MemoryWrite, Busy} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {Ack0, Ack1, Err0, Err1, MemoryRead, MemoryWrite, Busy});
      end
      n_tests++;
      if ({RData0, RData1, MemAddress, MemWriteData} !== 128'b0) begin
         n_fail++;
         $display("FAIL reset_data: got %h %h %h %h want all zero",
                  RData0, RData1, MemAddress, MemWriteData);
      end
      @(negedge Clock);
      ResetL = 1;
      tick();
   endtask

   task automatic test_write_read();
      logic [31:0] rd; bit err; int lat, nrd, nwr;
      run_access(0, 1, 32'h10, 32'hDEADBEEF, rd, err, lat, nrd, nwr);
      n_tests++;
      if ({lat, nrd, nwr, 31'b0, err} !== {32'd3, 32'd0, 32'd1, 32'd0}) begin
         n_fail++;
         $display("FAIL write_0x10: lat=%0d rd=%0d wr=%0d err=%b want 3 0 1 0", lat, nrd, nwr, err);
      end
      n_tests++;
      if (mem[4] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL write_mem: got %h want deadbeef", mem[4]);
      end
      run_access(0, 0, 32'h10, 32'h0, rd, err, lat, nrd, nwr);
      n_tests++;
      if ({lat, nrd, nwr, 31'b0, err} !== {32'd3, 32'd1, 32'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL read_0x10: lat=%0d rd=%0d wr=%0d err=%b want 3 1 0 0", lat, nrd, nwr, err);
      end
      n_tests++;
      if (rd !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL read_data: got %h want deadbeef", rd);
      end
      n_tests++;
      if (MemAddress !== 32'h10) begin
         n_fail++;
         $display("FAIL addr_hold: got %h want 00000010", MemAddress);
      end
   endtask

   task automatic test_illegal_write();
      logic [31:0] rd; bit err; int lat, nrd, nwr;
      run_access(1, 1, 32'h3FC, 32'h55AA55AA, rd, err, lat, nrd, nwr);
      n_tests++;
      if ({lat, nrd, nwr, 31'b0, err} !== {32'd3, 32'd0, 32'd0, 32'd1}) begin
         n_fail++;
         $display("FAIL ill_write: lat=%0d rd=%0d wr=%0d err=%b want 3 0 0 1", lat, nrd, nwr, err);
      end
      run_access(1, 0, 32'hFC, 32'h0, rd, err, lat, nrd, nwr);
      n_tests++;
      if ({rd, 31'b0, err, nrd} !== {32'hA000003F, 32'd0, 32'd1}) begin
         n_fail++;
         $display("FAIL read_w63: data=%h err=%b rd=%0d want a000003f 0 1", rd, err, nrd);
      end
   endtask

   task automatic test_illegal_read();
      logic [31:0] rd; bit err; int lat, nrd, nwr;
      logic [31:0] addrs [2];
      addrs[0] = 32'h100;
      addrs[1] = 32'h6;
      for (int i = 0; i < 2; i++) begin
         run_access(1, 0, addrs[i], 32'h0, rd, err, lat, nrd, nwr);
         n_tests++;
         if ({lat, rd, nrd, nwr, 31'b0, err} !== {32'd3, 32'd0, 32'd0, 32'd0, 32'd1}) begin
            n_fail++;
            $display("FAIL ill_read_%h: lat=%0d data=%h rd=%0d wr=%0d err=%b want 3 0 0 0 1",
                     addrs[i], lat, rd, nrd, nwr, err);
         end
      end
   endtask

   task automatic test_tie();
      int order [4];
      int exp_order [4];
      int n_ack, cycles, both;
`ifdef DMEM_ARB_RR_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{0, 0, 0, 0};
`endif
      @(negedge Clock);
      ResetL = 0;
      #2 ResetL = 1;
      tick();
      n_ack = 0; cycles = 0; both = 0;
      Req0 = 1; We0 = 0; Addr0 = 32'h10;
      Req1 = 1; We1 = 0; Addr1 = 32'h3C;
      while (n_ack < 4 && cycles < 40) begin
         tick();
         cycles++;
         if (Ack0 && Ack1) both++;
         if (Ack0) begin order[n_ack] = 0; n_ack++; end
         else if (Ack1) begin order[n_ack] = 1; n_ack++; end
      end
      Req0 = 0; Req1 = 0;
      tick();
      tick();
      n_tests++;
      if ({n_ack, both} !== {32'd4, 32'd0}) begin
         n_fail++;
         $display("FAIL tie_acks: got %0d acks, %0d double want 4 0", n_ack, both);
      end
      for (int i = 0; i < n_ack; i++) begin
         n_tests++;
         if (order[i] !== exp_order[i]) begin
            n_fail++;
            $display("FAIL tie_grant_%0d: got port %0d want port %0d", i, order[i], exp_order[i]);
         end
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] rd; bit err; int lat, nrd, nwr, acks;
      Req0 = 1; We0 = 1; Addr0 = 32'h20; WData0 = 32'h12345678;
      tick();
      n_tests++;
      if (MemoryWrite !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_strobe_on: MemoryWrite=%b want 1", MemoryWrite);
      end
      #1 ResetL = 0;
      #1;
      n_tests++;
      if ({MemoryWrite, MemoryRead, Busy, Ack0, MemAddress} !== 36'b0) begin
         n_fail++;
         $display("FAIL abort_reset: wr=%b rd=%b busy=%b ack=%b addr=%h want 0 0 0 0 0",
                  MemoryWrite, MemoryRead, Busy, Ack0, MemAddress);
      end
      Req0 = 0;
      @(negedge Clock);
      #1 ResetL = 1;
      acks = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         acks += int'(Ack0 | Ack1);
      end
      n_tests++;
      if (acks !== 0 || mem[8] !== 32'hA0000008) begin
         n_fail++;
         $display("FAIL abort_noack: acks=%0d mem8=%h want 0 a0000008", acks, mem[8]);
      end
      run_access(0, 0, 32'h20, 32'h0, rd, err, lat, nrd, nwr);
      n_tests++;
      if (rd !== 32'hA0000008) begin
         n_fail++;
         $display("FAIL abort_readback: got %h want a0000008", rd);
      end
   endtask

   task automatic test_back_to_back();
      int lat, gap, busy_low;
      logic [31:0] rd2;
      Req0 = 1; We0 = 0; Addr0 = 32'h10;
      lat = 0;
      while (!Ack0 && lat < 20) begin tick(); lat++; end
      gap = 0; busy_low = 0;
      do begin
         tick();
         gap++;
         if (!Busy) busy_low++;
      end while (!Ack0 && gap < 20);
      rd2 = RData0;
      Req0 = 0;
      tick();
      tick();
      n_tests++;
      if (lat !== 3 || gap !== 4) begin
         n_fail++;
         $display("FAIL b2b_timing: first=%0d gap=%0d want 3 4", lat, gap);
      end
      n_tests++;
      if (busy_low !== 1) begin
         n_fail++;
         $display("FAIL b2b_busy_low: got %0d cycles want 1", busy_low);
      end
      n_tests++;
      if (rd2 !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL b2b_data: got %h want deadbeef", rd2);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_illegal_write();
      test_illegal_read();
      test_tie();
      test_reset_abort();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
